life_engine: RTL and testbench

Parametrised Game-of-Life compute engine for a toroidal or bounded W×H board held in on-block registers. It evaluates one cell per cycle using a programmable birth/survive rule and a parallel 8-neighbour count, and accumulates the next-generation population count. The new generation is committed atomically in a single cycle, gated by an external commit strobe, typically vsync. It sits between the UART command FSM, which drives start and cell writes, and the VGA/UART renderers, which use the read port.

---
 rtl/life_engine.sv | 185 ++++++++++++++++++
 tb/tb_life_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | life_engine                                                                |
// | Game-of-Life engine: one cell per cycle, rule masks, gated atomic commit.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module life_engine #(
  parameter int LOG_W = 3,
  parameter int LOG_H = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8:0]             birth_mask,
  input  logic [8:0]             survive_mask,
  input  logic                   commit_en,
  input  logic                   wr_en,
  input  logic [LOG_W+LOG_H-1:0] wr_addr,
  input  logic                   wr_data,
  input  logic [LOG_W+LOG_H-1:0] rd_addr,
  output logic                   rd_data,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            generation,
  output logic [LOG_W+LOG_H:0]   population
);

  localparam int W  = 2 ** LOG_W;
  localparam int H  = 2 ** LOG_H;
  localparam int N  = W * H;
  localparam int AW = LOG_W + LOG_H;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    cur_q, cur_d;
  logic [N-1:0]    nxt_q, nxt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW:0]     pop_acc_q, pop_acc_d;
  logic [8:0]      birth_q, birth_d;
  logic [8:0]      survive_q, survive_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     gen_q, gen_d;
  logic [AW:0]     pop_q, pop_d;

  logic [LOG_W-1:0] w_cur_x;
  logic [LOG_H-1:0] w_cur_y;
  logic [8:0]       w_nbr_bits;
  logic [3:0]       w_nbr_cnt;
  logic [15:0]      w_birth_ext;
  logic [15:0]      w_survive_ext;
  logic             w_new_cell;

  assign w_cur_x = idx_q[LOG_W-1:0];
  assign w_cur_y = idx_q[AW-1:LOG_W];

  // Offsets 0/1/2 map to -1/0/+1; adding (off + size - 1) mod size wraps for free.
  for (genvar dy = 0; dy < 3; dy++) begin : g_row
    for (genvar dx = 0; dx < 3; dx++) begin : g_col
      if (dx == 1 && dy == 1) begin : g_self
        assign w_nbr_bits[dy*3+dx] = 1'b0;
      end else begin : g_nbr
        localparam logic [LOG_W-1:0] C_OFF_X = LOG_W'(dx + W - 1);
        localparam logic [LOG_H-1:0] C_OFF_Y = LOG_H'(dy + H - 1);
        logic [LOG_W-1:0] w_nx;
        logic [LOG_H-1:0] w_ny;
        logic             w_off_board;
        assign w_nx = w_cur_x + C_OFF_X;
        assign w_ny = w_cur_y + C_OFF_Y;
        assign w_off_board = !WRAP &&
                             ((dx == 0 && w_cur_x == '0) ||
                              (dx == 2 && w_cur_x == {LOG_W{1'b1}}) ||
                              (dy == 0 && w_cur_y == '0) ||
                              (dy == 2 && w_cur_y == {LOG_H{1'b1}}));
        assign w_nbr_bits[dy*3+dx] = !w_off_board && cur_q[{w_ny, w_nx}];
      end
    end
  end

  always_comb begin
    w_nbr_cnt = 4'd0;
    for (int k = 0; k < 9; k++) begin
      w_nbr_cnt = w_nbr_cnt + {3'b000, w_nbr_bits[k]};
    end
  end

  assign w_birth_ext   = {7'd0, birth_q};
  assign w_survive_ext = {7'd0, survive_q};
  assign w_new_cell    = cur_q[idx_q] ? w_survive_ext[w_nbr_cnt] : w_birth_ext[w_nbr_cnt];

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    idx_d     = idx_q;
    pop_acc_d = pop_acc_q;
    birth_d   = birth_q;
    survive_d = survive_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    gen_d     = gen_q;
    pop_d     = pop_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          cur_d[wr_addr] = wr_data;
        end
        if (start) begin
          birth_d   = birth_mask;
          survive_d = survive_mask;
          idx_d     = '0;
          pop_acc_d = '0;
          busy_d    = 1'b1;
          state_d   = S_UPDATE;
        end
      end
      S_UPDATE: begin
        nxt_d[idx_q] = w_new_cell;
        pop_acc_d    = pop_acc_q + {{AW{1'b0}}, w_new_cell};
        if (idx_q == {AW{1'b1}}) begin
          idx_d   = '0;
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_COMMIT: begin
        if (commit_en) begin
          cur_d   = nxt_q;
          gen_d   = gen_q + 16'd1;
          pop_d   = pop_acc_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      nxt_q     <= '0;
      idx_q     <= '0;
      pop_acc_q <= '0;
      birth_q   <= '0;
      survive_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gen_q     <= '0;
      pop_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      idx_q     <= idx_d;
      pop_acc_q <= pop_acc_d;
      birth_q   <= birth_d;
      survive_q <= survive_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gen_q     <= gen_d;
      pop_q     <= pop_d;
    end
  end

  assign rd_data    = cur_q[rd_addr];
  assign busy       = busy_q;
  assign done       = done_q;
  assign generation = gen_q;
  assign population = pop_q;

endmodule
`default_nettype wire

// File: tb/tb_life_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_life_engine                                                             |
// | Directed bench: toroidal and bounded engines driven from shared inputs.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_life_engine;

  localparam logic [8:0] C_CONWAY_B = 9'h008;
  localparam logic [8:0] C_CONWAY_S = 9'h00C;
  localparam logic [8:0] C_HIGH_B   = 9'h048;
  localparam logic [63:0] C_BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] C_BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] C_GLIDER  = 64'h0000_0000_0007_0402;
  localparam logic [63:0] C_CORNER  = 64'h0000_0000_0000_0103;
  localparam logic [63:0] C_BLOCK   = 64'h0000_0000_0000_0303;
  localparam logic [63:0] C_SIX     = 64'h0000_0004_141C_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, commit_en, wr_en, wr_data;
  logic [8:0] birth_mask, survive_mask;
  logic [5:0] wr_addr, rd_addr;

  logic        rd_t, busy_t, done_t;
  logic [15:0] gen_t;
  logic [6:0]  pop_t;
  logic        rd_b, busy_b, done_b;
  logic [15:0] gen_b;
  logic [6:0]  pop_b;

  life_engine #(.LOG_W(3), .LOG_H(3), .WRAP(1'b1)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start), .birth_mask(birth_mask),
    .survive_mask(survive_mask), .commit_en(commit_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_t),
    .busy(busy_t), .done(done_t), .generation(gen_t), .population(pop_t)
  );

  life_engine #(.LOG_W(3), .LOG_H(3), .WRAP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .birth_mask(birth_mask),
    .survive_mask(survive_mask), .commit_en(commit_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_b),
    .busy(busy_b), .done(done_b), .generation(gen_b), .population(pop_b)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] bt, bb;
  int lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Only called while the board is stable (idle or waiting for commit).
  task automatic read_board(output logic [63:0] ot, output logic [63:0] ob);
    for (int i = 0; i < 64; i++) begin
      rd_addr = 6'(i);
      #1;
      ot[i] = rd_t;
      ob[i] = rd_b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_cell(input int a, input logic v);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic seed(input logic [63:0] b);
    for (int i = 0; i < 64; i++) begin
      if (b[i]) write_cell(i, 1'b1);
    end
  endtask

  // lat counts edges after the start edge up to the edge that raises done.
  task automatic run_gen(input logic [8:0] bm, input logic [8:0] sm, output int l);
    @(negedge clk);
    start = 1'b1; birth_mask = bm; survive_mask = sm; commit_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    birth_mask = ~bm; survive_mask = ~sm;
    l = 0;
    check("busy_after_start", busy_t, 1);
    while (!done_t && l < 2000) begin
      @(negedge clk);
      l++;
    end
    check("done_seen", done_t, 1);
    check("busy_low_with_done", busy_t, 0);
    @(negedge clk);
    check("done_one_cycle", done_t, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic busy_drop, done_seen;
    rst_n = 1'b0; start = 1'b0; commit_en = 1'b1; wr_en = 1'b0; wr_data = 1'b0;
    birth_mask = C_CONWAY_B; survive_mask = C_CONWAY_S; wr_addr = '0; rd_addr = '0;
    do_reset();

    // Reset state
    check("rst_busy", busy_t, 0);
    check("rst_done", done_t, 0);
    check("rst_gen", gen_t, 0);
    check("rst_pop", pop_t, 0);
    read_board(bt, bb);
    check("rst_board", bt, 64'h0);

    // Blinker
    seed(C_BLINK_H);
    run_gen(C_CONWAY_B, C_CONWAY_S, lat);
    check("blink1_lat", 64'(lat), 65);
    read_board(bt, bb);
    check("blink1_board", bt, C_BLINK_V);
    check("blink1_pop", pop_t, 3);
    check("blink1_gen", gen_t, 1);
    run_gen(C_CONWAY_B, C_CONWAY_S, lat);
    check("blink2_lat", 64'(lat), 65);
    read_board(bt, bb);
    check("blink2_board", bt, C_BLINK_H);
    check("blink2_pop", pop_t, 3);
    check("blink2_gen", gen_t, 2);

    // Glider around the torus
    do_reset();
    seed(C_GLIDER);
    for (int g = 0; g < 32; g++) begin
      run_gen(C_CONWAY_B, C_CONWAY_S, lat);
      check("glider_pop", pop_t, 5);
    end
    read_board(bt, bb);
    check("glider_board", bt, C_GLIDER);
    check("glider_gen", gen_t, 32);

    // Corner seed: bounded vs toroidal
    do_reset();
    seed(C_CORNER);
    run_gen(C_CONWAY_B, C_CONWAY_S, lat);
    read_board(bt, bb);
    check("bounded_board", bb, C_BLOCK);
    check("bounded_pop", pop_b, 4);
    check("wrap_board", bt, C_BLOCK);
    check("wrap_corners", {61'd0, bt[63], bt[56], bt[7]}, 0);

    // Six-neighbour birth: HighLife vs Conway
    do_reset();
    seed(C_SIX);
    run_gen(C_HIGH_B, C_CONWAY_S, lat);
    read_board(bt, bb);
    check("highlife_birth", bt[27], 1);
    do_reset();
    seed(C_SIX);
    run_gen(C_CONWAY_B, C_CONWAY_S, lat);
    read_board(bt, bb);
    check("conway_no_birth", bt[27], 0);

    // Commit gating and busy protection
    do_reset();
    seed(C_BLINK_H);
    @(negedge clk);
    start = 1'b1; birth_mask = C_CONWAY_B; survive_mask = C_CONWAY_S; commit_en = 1'b0;
    busy_drop = 1'b0; done_seen = 1'b0;
    for (int c = 1; c <= 164; c++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (c == 10) begin
        wr_en = 1'b1; wr_addr = 6'd27; wr_data = 1'b0;
      end
      if (c == 80) begin
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 1'b1;
        start = 1'b1; birth_mask = 9'h1FF; survive_mask = 9'h1FF;
      end
      if (!busy_t) busy_drop = 1'b1;
      if (done_t) done_seen = 1'b1;
    end
    check("gate_busy_held", busy_drop, 0);
    check("gate_no_done", done_seen, 0);
    read_board(bt, bb);
    check("gate_cur_unchanged", bt, C_BLINK_H);
    @(negedge clk);
    commit_en = 1'b1;
    @(negedge clk);
    check("gate_done", done_t, 1);
    check("gate_busy_low", busy_t, 0);
    @(negedge clk);
    check("gate_done_pulse", done_t, 0);
    repeat (3) @(negedge clk);
    check("gate_start_not_queued", busy_t, 0);
    read_board(bt, bb);
    check("gate_board", bt, C_BLINK_V);
    check("gate_gen", gen_t, 1);

    // Reset in the middle of an update
    do_reset();
    seed(C_BLINK_H);
    @(negedge clk);
    start = 1'b1; birth_mask = C_CONWAY_B; survive_mask = C_CONWAY_S; commit_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy_t, 0);
    check("abort_gen", gen_t, 0);
    check("abort_pop", pop_t, 0);
    done_seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done_t) done_seen = 1'b1;
    end
    check("abort_no_done", done_seen, 0);
    read_board(bt, bb);
    check("abort_board", bt, 64'h0);
    seed(C_BLINK_H);
    run_gen(C_CONWAY_B, C_CONWAY_S, lat);
    check("fresh_lat", 64'(lat), 65);
    read_board(bt, bb);
    check("fresh_board", bt, C_BLINK_V);
    check("fresh_gen", gen_t, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
